// File: rtl/skut_frame_reader_pkg.sv
// skut_frame_reader_pkg: shared SKUT frame constants and reader FSM states
package skut_frame_reader_pkg;
   localparam int SKUT_WORDS = 80;
   localparam int SKUT_RAM_DEPTH = 128;
   localparam int SKUT_ADDR_W = $clog2(SKUT_RAM_DEPTH);
   typedef enum logic [2:0] {IDLE, FETCH, WAIT, LOAD, SHIFT} state_t;
endpackage

// File: rtl/skut_frame_reader_if.sv
// skut_frame_reader_if: frame strobe, bit enable, RAM read port and serial outputs
interface skut_frame_reader_if
   import skut_frame_reader_pkg::*;
#(
   parameter int ADDR_W = SKUT_ADDR_W
);
   logic              i8KHz;
   logic              iBitEn;
   logic [7:0]        iRdData;
   logic [ADDR_W-1:0] oRdAddr;
   logic              oRdEn;
   logic              oSerial;
   logic              oWordSync;
   logic              oFrameSync;
   logic              oBusy;
   logic              oOverrun;
   modport master (
      input  i8KHz, iBitEn, iRdData,
      output oRdAddr, oRdEn, oSerial, oWordSync, oFrameSync, oBusy, oOverrun
   );
   modport slave (
      output i8KHz, iBitEn, iRdData,
      input  oRdAddr, oRdEn, oSerial, oWordSync, oFrameSync, oBusy, oOverrun
   );
endinterface

// File: rtl/skut_frame_reader_edge_sync.sv
// skut_edge_sync: 2-FF synchroniser with rising-edge detect for slow strobes
module skut_edge_sync (
   input  logic iClk,
   input  logic reset,
   input  logic strobe,
   output logic rise
);
   logic [2:0] s;
   // s[0], s[1] synchronise; s[2] holds the previous synchronised level
   always_ff @(posedge iClk) s <= reset ? 3'b000 : {s[1:0], strobe};
   assign rise = s[1] & ~s[2];
endmodule

// File: rtl/skut_frame_reader.sv
// skut_frame_reader: fetches 80 frame words per 8 kHz edge and serialises them MSB-first
module skut_frame_reader
   import skut_frame_reader_pkg::*;
#(
   parameter int WORDS  = SKUT_WORDS,
   parameter int ADDR_W = SKUT_ADDR_W,
   parameter int RD_LAT = 1
) (
   input logic iClk,
   input logic reset,
   skut_frame_reader_if.master bus
);
   localparam logic [ADDR_W-1:0] LAST = ADDR_W'(WORDS - 1);
   state_t            state, state_n;
   logic              rise, bit_en, edge_bit, load, fin, cap;
   logic [ADDR_W-1:0] idx;
   logic [1:0]        lat_cnt;
   logic [7:0]        hold, shreg;
   logic [2:0]        bitcnt;
   logic              hold_valid, err;

   skut_edge_sync u_sync (.iClk(iClk), .reset(reset), .strobe(bus.i8KHz), .rise(rise));

   // idx counts loaded words, so shifting is live only after the first word is in shreg
   assign bit_en   = bus.iBitEn && state != IDLE && idx != '0;
   assign edge_bit = bit_en && bitcnt == 3'd7;

   // next state plus load/finish/capture strobes; the next word is prefetched right after each load
   always_comb begin
      state_n = state;
      load    = 1'b0;
      fin     = 1'b0;
      cap     = state == WAIT && lat_cnt == 2'(RD_LAT);
      case (state)
         IDLE:  state_n = rise ? FETCH : IDLE;
         FETCH: state_n = WAIT;
         WAIT:  state_n = cap ? (idx == '0 ? LOAD : SHIFT) : WAIT;
         LOAD: begin
            load    = 1'b1;
            state_n = idx < LAST ? FETCH : SHIFT;
         end
         SHIFT: begin
            load    = edge_bit && idx <= LAST;
            fin     = edge_bit && idx > LAST;
            state_n = fin ? IDLE : (load && idx < LAST) ? FETCH : SHIFT;
         end
         default: state_n = IDLE;
      endcase
   end

   // state register
   always_ff @(posedge iClk) state <= reset ? IDLE : state_n;

   // read port, word hold and shift register, framing flags
   always_ff @(posedge iClk) begin
      if (reset) begin
         bus.oRdAddr    <= '0;
         bus.oRdEn      <= 1'b0;
         bus.oSerial    <= 1'b0;
         bus.oWordSync  <= 1'b0;
         bus.oFrameSync <= 1'b0;
         bus.oBusy      <= 1'b0;
         bus.oOverrun   <= 1'b0;
         idx            <= '0;
         lat_cnt        <= '0;
         hold           <= '0;
         hold_valid     <= 1'b0;
         shreg          <= '0;
         bitcnt         <= '0;
         err            <= 1'b0;
      end else begin
         bus.oRdEn    <= state == FETCH;
         bus.oOverrun <= rise && bus.oBusy;
         lat_cnt      <= state == WAIT ? lat_cnt + 2'd1 : 2'd0;
         if (state == FETCH) bus.oRdAddr <= idx;
         if (state == IDLE && rise) begin
            bus.oBusy <= 1'b1;
            idx       <= '0;
         end
         if (cap) begin
            hold       <= bus.iRdData;
            hold_valid <= 1'b1;
         end
         if (load) begin
            shreg          <= hold;
            bus.oSerial    <= hold_valid & hold[7];
            bitcnt         <= '0;
            hold_valid     <= 1'b0;
            bus.oWordSync  <= 1'b1;
            bus.oFrameSync <= idx == '0;
            idx            <= idx + 1'b1;
            err            <= err | ~hold_valid;
         end else if (fin) begin
            bus.oSerial    <= 1'b0;
            bus.oWordSync  <= 1'b0;
            bus.oFrameSync <= 1'b0;
            bus.oBusy      <= 1'b0;
         end else if (bit_en) begin
            shreg          <= {shreg[6:0], 1'b0};
            bus.oSerial    <= shreg[6];
            bitcnt         <= bitcnt + 3'd1;
            bus.oWordSync  <= 1'b0;
            bus.oFrameSync <= 1'b0;
         end
      end
   end

   hold_underrun: assert property (@(posedge iClk) disable iff (reset) !err);
endmodule

// File: tb/tb_skut_frame_reader.sv
// tb_skut_frame_reader: scoreboard bench; expected bit stream built from RAM contents per frame
module tb_skut_frame_reader;
   import skut_frame_reader_pkg::*;
   localparam int LAT   = 2;
   localparam int NBITS = SKUT_WORDS * 8;
   logic       iClk = 1'b0;
   logic       reset = 1'b1;
   int         n_pass = 0, n_chk = 0, exp_ovr = 0, ovr_cnt = 0, bit_per = 4;
   logic [7:0] mem [SKUT_RAM_DEPTH];
   logic [7:0] p1 = '0, p2 = '0;
   logic [2:0] exp_q [$];

   skut_frame_reader_if bus ();
   skut_frame_reader #(.RD_LAT(LAT)) dut (.iClk(iClk), .reset(reset), .bus(bus));

   always #5 iClk = ~iClk;

   // synchronous RAM with LAT-cycle read latency; idle cycles read as zero
   always @(posedge iClk) begin
      p1 <= bus.oRdEn ? mem[bus.oRdAddr] : 8'h00;
      p2 <= p1;
   end
   assign bus.iRdData = LAT == 2 ? p2 : p1;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge iClk);
         #1;
      end
   endtask

   // free-running bit enable, one pulse every bit_per clocks
   initial begin
      int cnt = 0;
      bus.iBitEn = 1'b0;
      forever begin
         @(posedge iClk);
         #1;
         bus.iBitEn = cnt >= bit_per - 1;
         cnt = bus.iBitEn ? 0 : cnt + 1;
      end
   end

   // monitor: the bit held when iBitEn arrives is the one being completed
   initial begin
      int         left = 0;
      bit         end_chk = 1'b0;
      logic [2:0] e;
      forever begin
         @(negedge iClk);
         if (reset) begin
            exp_q.delete();
            left = 0;
            end_chk = 1'b0;
         end else begin
            if (bus.oOverrun) ovr_cnt++;
            if (end_chk) begin
               chk("frame_end_idle", 32'({bus.oBusy, bus.oSerial, bus.oWordSync, bus.oFrameSync}), 0);
               end_chk = 1'b0;
            end
            if (bus.iBitEn && (left > 0 || bus.oFrameSync)) begin
               if (left == 0) left = NBITS;
               if (exp_q.size() == 0) chk("bit_unexpected", 1, 0);
               else begin
                  e = exp_q.pop_front();
                  chk("bit_fs_ws_serial", 32'({bus.oFrameSync, bus.oWordSync, bus.oSerial}), 32'(e));
               end
               left--;
               end_chk = left == 0;
            end
         end
      end
   end

   task automatic start_frame();
      int k = 0;
      for (int w = 0; w < SKUT_WORDS; w++)
         for (int b = 7; b >= 0; b--)
            exp_q.push_back({w == 0 && b == 7, b == 7, mem[w][b]});
      bus.i8KHz = 1'b1;
      while (!bus.oRdEn && k < 20) begin
         tick(1);
         k++;
      end
      chk("first_rden_latency", k, 4);
      chk("first_rd_addr", 32'(bus.oRdAddr), 0);
      tick(3);
      bus.i8KHz = 1'b0;
   endtask

   task automatic wait_idle();
      int k = 0;
      while (bus.oBusy && k < 20000) begin
         tick(1);
         k++;
      end
      chk("frame_done_in_time", 32'(k < 20000), 1);
      tick(5);
      chk("queue_drained", 32'(exp_q.size()), 0);
   endtask

   initial begin
      bus.i8KHz = 1'b0;
      for (int a = 0; a < SKUT_RAM_DEPTH; a++) mem[a] = 8'(a);
      tick(3);
      chk("reset_state", 32'({bus.oRdAddr, bus.oRdEn, bus.oSerial, bus.oWordSync,
                              bus.oFrameSync, bus.oBusy, bus.oOverrun}), 0);
      reset = 1'b0;
      tick(5);
      bit_per = 4;
      start_frame();
      wait_idle();
      foreach (mem[a]) mem[a] = 8'h00;
      mem[0]  = 8'hDC;
      mem[38] = 8'h7C;
      start_frame();
      wait_idle();
      foreach (mem[a]) mem[a] = 8'($urandom);
      bit_per = 2;
      start_frame();
      wait_idle();
      foreach (mem[a]) mem[a] = 8'($urandom);
      bit_per = $urandom_range(2, 6);
      start_frame();
      tick(600);
      bus.i8KHz = 1'b1;
      exp_ovr++;
      tick(4);
      bus.i8KHz = 1'b0;
      wait_idle();
      start_frame();
      wait_idle();
      bit_per = 3;
      start_frame();
      tick(6 * 8 * 3 + 10);
      reset = 1'b1;
      tick(1);
      chk("mid_reset_outputs", 32'({bus.oBusy, bus.oSerial, bus.oRdEn, bus.oWordSync, bus.oFrameSync}), 0);
      tick(2);
      reset = 1'b0;
      tick(3);
      foreach (mem[a]) mem[a] = 8'($urandom);
      start_frame();
      wait_idle();
      chk("overrun_pulse_cycles", ovr_cnt, exp_ovr);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
